// File: rtl/btn_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : btn_ctrl_pkg
//  Purpose  : Shared types and constants for the push-button counter
//             controller: FSM states, counter operations, button priority.
//  Revision : 1.0 - initial release
// ============================================================================
package btn_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FIRE     = 2'd1,
        WAIT_REL = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_CLR  = 2'd1,
        OP_UP   = 2'd2,
        OP_DN   = 2'd3
    } op_e;

    localparam int C_NUM_BTN = 3;

    // Highest priority first.
    localparam op_e C_PRIO_ORDER [C_NUM_BTN] = '{OP_CLR, OP_UP, OP_DN};

    // req is indexed by op_e value; returns the highest-priority requested op.
    function automatic op_e pick_op(input logic [3:0] req);
        op_e g;
        g = OP_NONE;
        // Walk from lowest to highest priority so the highest one wins last.
        for (int i = C_NUM_BTN - 1; i >= 0; i--) begin
            if (req[C_PRIO_ORDER[i]]) begin
                g = C_PRIO_ORDER[i];
            end
        end
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_counter_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : btn_counter_ctrl_if
//  Purpose  : Button inputs and counter/status outputs of the controller.
//             master = board side driving buttons, slave = controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface btn_counter_ctrl_if #(
    parameter int CNT_W = 3
);
    logic             btn_up;
    logic             btn_dn;
    logic             btn_clr;
    logic [CNT_W-1:0] counter;
    logic             cmd_pulse;
    logic             busy;
    logic             led;

    modport master (
        output btn_up, btn_dn, btn_clr,
        input  counter, cmd_pulse, busy, led
    );

    modport slave (
        input  btn_up, btn_dn, btn_clr,
        output counter, cmd_pulse, busy, led
    );
endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce
//  Purpose  : 2-flop synchroniser plus tick-sampled shift register; reports
//             a stable high / stable low level for one raw button.
//  Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEB_LEN = 7
) (
    input  wire logic MHz,
    input  wire logic rst,
    input  wire logic tick,
    input  wire logic raw,
    output logic      stable_hi,
    output logic      stable_lo
);
    logic [1:0]         sync_q, sync_d;
    logic [DEB_LEN-1:0] shift_q, shift_d;

    // Synchronise the raw level; shift it into the history only on a tick.
    always_comb begin
        sync_d  = {sync_q[0], raw};
        shift_d = shift_q;
        if (tick) begin
            shift_d = (shift_q << 1) | DEB_LEN'(sync_q[1]);
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge MHz or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            shift_q <= '0;
        end else begin
            sync_q  <= sync_d;
            shift_q <= shift_d;
        end
    end

    assign stable_hi = &shift_q;
    assign stable_lo = ~|shift_q;

endmodule
`default_nettype wire

// File: rtl/btn_counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : btn_counter_ctrl
//  Purpose  : Sample-tick divider, three debounced buttons and a sequencing
//             FSM issuing exactly one counter operation per button press.
//  Revision : 1.0 - initial release
// ============================================================================
module btn_counter_ctrl
    import btn_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 10000,
    parameter int DEB_LEN  = 7,
    parameter int CNT_W    = 3
) (
    input  wire logic           MHz,
    input  wire logic           rst,
    btn_counter_ctrl_if.slave   bus
);
    localparam int C_DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // ------------------------------------------------------------------
    // Reset: assert asynchronously, release two MHz edges later so every
    // flop leaves reset on the same clock.
    // ------------------------------------------------------------------
    logic [1:0] rst_pipe_q, rst_pipe_d;
    logic       rst_core;

    // Next value of the release pipe.
    always_comb begin
        rst_pipe_d = {rst_pipe_q[0], 1'b0};
    end

    // Reset synchroniser.
    always_ff @(posedge MHz or posedge rst) begin
        if (rst) begin
            rst_pipe_q <= 2'b11;
        end else begin
            rst_pipe_q <= rst_pipe_d;
        end
    end

    assign rst_core = rst_pipe_q[1];

    // ------------------------------------------------------------------
    // Sample tick divider
    // ------------------------------------------------------------------
    logic [C_DIV_W-1:0] div_q, div_d;
    logic               tick;

    assign tick = (div_q == C_DIV_W'(TICK_DIV - 1));

    // Count 0..TICK_DIV-1 and wrap.
    always_comb begin
        div_d = tick ? '0 : div_q + 1'b1;
    end

    // Divider register.
    always_ff @(posedge MHz or posedge rst_core) begin
        if (rst_core) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // ------------------------------------------------------------------
    // Debounced buttons
    // ------------------------------------------------------------------
    logic hi_up, hi_dn, hi_clr;
    logic lo_up, lo_dn, lo_clr;

    btn_debounce #(.DEB_LEN(DEB_LEN)) u_deb_up (
        .MHz(MHz), .rst(rst_core), .tick(tick), .raw(bus.btn_up),
        .stable_hi(hi_up), .stable_lo(lo_up)
    );

    btn_debounce #(.DEB_LEN(DEB_LEN)) u_deb_dn (
        .MHz(MHz), .rst(rst_core), .tick(tick), .raw(bus.btn_dn),
        .stable_hi(hi_dn), .stable_lo(lo_dn)
    );

    btn_debounce #(.DEB_LEN(DEB_LEN)) u_deb_clr (
        .MHz(MHz), .rst(rst_core), .tick(tick), .raw(bus.btn_clr),
        .stable_hi(hi_clr), .stable_lo(lo_clr)
    );

    // ------------------------------------------------------------------
    // Sequencing FSM with registered outputs
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    op_e              grant_q, grant_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic             cmd_pulse_q, cmd_pulse_d;
    logic             busy_q, busy_d;

    // Next state: grant on first stable press, apply once, then wait for
    // every button to be released before accepting another press.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        counter_d   = counter_q;
        cmd_pulse_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hi_up || hi_dn || hi_clr) begin
                    grant_d = pick_op({hi_dn, hi_up, hi_clr, 1'b0});
                    state_d = FIRE;
                end
            end
            FIRE: begin
                case (grant_q)
                    OP_CLR:  counter_d = '0;
                    OP_UP:   counter_d = counter_q + 1'b1;
                    OP_DN:   counter_d = counter_q - 1'b1;
                    default: counter_d = counter_q;
                endcase
                cmd_pulse_d = 1'b1;
                state_d     = WAIT_REL;
            end
            WAIT_REL: begin
                if (lo_up && lo_dn && lo_clr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // FSM and output registers.
    always_ff @(posedge MHz or posedge rst_core) begin
        if (rst_core) begin
            state_q     <= IDLE;
            grant_q     <= OP_NONE;
            counter_q   <= '0;
            cmd_pulse_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            counter_q   <= counter_d;
            cmd_pulse_q <= cmd_pulse_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.counter   = counter_q;
    assign bus.cmd_pulse = cmd_pulse_q;
    assign bus.busy      = busy_q;
    assign bus.led       = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_btn_counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_btn_counter_ctrl
//  Purpose  : Self-checking bench for btn_counter_ctrl (TICK_DIV=4,
//             DEB_LEN=3, CNT_W=3) against a press-level counter model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_btn_counter_ctrl;

    localparam int TB_TICK     = 4;
    localparam int TB_DEB      = 3;
    localparam int TB_CNT_W    = 3;
    localparam int CNT_MOD     = 1 << TB_CNT_W;
    localparam int RELEASE_CYC = 40;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    btn_counter_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();

    btn_counter_ctrl #(
        .TICK_DIV(TB_TICK),
        .DEB_LEN (TB_DEB),
        .CNT_W   (TB_CNT_W)
    ) dut (
        .MHz(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // Running total of strobe cycles seen on the output.
    always @(negedge clk) begin
        if (bus.cmd_pulse === 1'b1) pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Mask bits: [2]=clr, [1]=up, [0]=dn.
    task automatic drive(input logic [2:0] m);
        bus.btn_clr = m[2];
        bus.btn_up  = m[1];
        bus.btn_dn  = m[0];
    endtask

    // One press event: clear has priority over up, up over down.
    function automatic int model_op(input int cur, input logic [2:0] m);
        if (m[2]) return 0;
        if (m[1]) return (cur + 1) % CNT_MOD;
        if (m[0]) return (cur + CNT_MOD - 1) % CNT_MOD;
        return cur;
    endfunction

    task automatic press(input logic [2:0] m, input int hold_ticks, input string tag);
        int p0;
        p0 = pulses;
        drive(m);
        repeat (hold_ticks * TB_TICK) @(negedge clk);
        chk($sformatf("%s_busy_held", tag), 32'(bus.busy), 32'(m != 3'b000));
        drive(3'b000);
        repeat (RELEASE_CYC) @(negedge clk);
        exp_cnt = model_op(exp_cnt, m);
        chk($sformatf("%s_pulses", tag), 32'(pulses - p0), 32'(m != 3'b000));
        chk($sformatf("%s_counter", tag), 32'(bus.counter), 32'(exp_cnt));
        chk($sformatf("%s_busy_rel", tag), 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int p0;
        int c0;
        logic [2:0] m;
        int hold;

        // ---------------- reset with toggling buttons ----------------
        rst = 1'b1;
        drive(3'b000);
        repeat (20) begin
            @(negedge clk);
            drive(3'($urandom_range(0, 7)));
            chk("rst_counter", 32'(bus.counter), 32'd0);
            chk("rst_busy", 32'(bus.busy), 32'd0);
            chk("rst_pulse", 32'(bus.cmd_pulse), 32'd0);
            chk("rst_led", 32'(bus.led), 32'd1);
        end
        drive(3'b000);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("post_rst_counter", 32'(bus.counter), 32'd0);

        // ---------------- up held 40 ticks ----------------
        p0 = pulses;
        drive(3'b010);
        repeat (40 * TB_TICK) @(negedge clk);
        chk("hold_pulses", 32'(pulses - p0), 32'd1);
        chk("hold_counter", 32'(bus.counter), 32'd1);
        chk("hold_busy", 32'(bus.busy), 32'd1);
        drive(3'b000);
        repeat (RELEASE_CYC) @(negedge clk);
        chk("hold_busy_rel", 32'(bus.busy), 32'd0);
        chk("hold_pulses_rel", 32'(pulses - p0), 32'd1);
        exp_cnt = 1;

        // ---------------- wrap both directions ----------------
        press(3'b100, 8, "wrap_clr");
        for (int i = 0; i < 7; i++) press(3'b010, 8, $sformatf("wrap_up%0d", i));
        chk("wrap_at_max", 32'(bus.counter), 32'd7);
        press(3'b010, 8, "wrap_up_over");
        chk("wrap_to_zero", 32'(bus.counter), 32'd0);
        press(3'b001, 8, "wrap_dn_under");
        chk("wrap_to_max", 32'(bus.counter), 32'd7);

        // ---------------- bounce shorter than the debounce window ----------------
        p0 = pulses;
        c0 = exp_cnt;
        for (int i = 0; i < 10; i++) begin
            bus.btn_up = i[0] ? 1'b0 : 1'b1;
            repeat (TB_TICK) @(negedge clk);
        end
        bus.btn_up = 1'b0;
        repeat (RELEASE_CYC) @(negedge clk);
        chk("bounce_pulses", 32'(pulses - p0), 32'd0);
        chk("bounce_counter", 32'(bus.counter), 32'(c0));
        chk("bounce_busy", 32'(bus.busy), 32'd0);

        // ---------------- second button pressed while busy is ignored ----------------
        p0 = pulses;
        drive(3'b010);
        repeat (10 * TB_TICK) @(negedge clk);
        drive(3'b011);
        repeat (10 * TB_TICK) @(negedge clk);
        drive(3'b000);
        repeat (RELEASE_CYC) @(negedge clk);
        exp_cnt = model_op(exp_cnt, 3'b010);
        chk("busy_ignore_pulses", 32'(pulses - p0), 32'd1);
        chk("busy_ignore_counter", 32'(bus.counter), 32'(exp_cnt));

        // ---------------- simultaneous press at counter=5 ----------------
        press(3'b100, 8, "sim_clr");
        for (int i = 0; i < 5; i++) press(3'b010, 8, $sformatf("sim_up%0d", i));
        chk("sim_pre", 32'(bus.counter), 32'd5);
        press(3'b111, 10, "sim_all");
        chk("sim_result", 32'(bus.counter), 32'd0);

        // ---------------- randomized presses ----------------
        for (int i = 0; i < 12; i++) begin
            m    = 3'($urandom_range(1, 7));
            hold = int'($urandom_range(8, 20));
            press(m, hold, $sformatf("rnd%0d_m%0d", i, m));
        end

        // ---------------- reset in WAIT_REL ----------------
        press(3'b100, 8, "mid_clr");
        press(3'b010, 8, "mid_up0");
        press(3'b010, 8, "mid_up1");
        drive(3'b010);
        repeat (10 * TB_TICK) @(negedge clk);
        chk("mid_counter3", 32'(bus.counter), 32'd3);
        chk("mid_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_counter", 32'(bus.counter), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_pulse", 32'(bus.cmd_pulse), 32'd0);
        repeat (5) @(negedge clk);
        p0 = pulses;
        rst = 1'b0;
        repeat (12 * TB_TICK) @(negedge clk);
        chk("after_rst_pulses", 32'(pulses - p0), 32'd1);
        chk("after_rst_counter", 32'(bus.counter), 32'd1);
        chk("after_rst_busy", 32'(bus.busy), 32'd1);
        drive(3'b000);
        repeat (RELEASE_CYC) @(negedge clk);
        chk("after_rst_busy_rel", 32'(bus.busy), 32'd0);
        chk("after_rst_pulses_rel", 32'(pulses - p0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
